axis_flit_deserializer: RTL

- Single-clock NoC egress endpoint. Accepts flits from a router output port under credit-based flow control, buffers them, and reassembles SERIALIZATION_FACTOR flits into one AXI-Stream beat.
- It is the receive-side counterpart of the flit serializer that feeds router inputs. It sits between a mesh output port and a user AXIS sink, in the NoC clock domain.

---
 rtl/axis_flit_deserializer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/axis_flit_deserializer.sv
// rtl/axis_flit_deserializer.sv - credit-flow NoC egress endpoint reassembling flits into AXI-Stream beats
module axis_flit_deserializer_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
      if (wr_en && !rd_en)      count <= count + CNT_W'(1);
      else if (!wr_en && rd_en) count <= count - CNT_W'(1);
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
endmodule

module axis_flit_deserializer #(
  parameter  int TDEST_WIDTH          = 6,
  parameter  int TDATA_WIDTH          = 512,
  parameter  int SERIALIZATION_FACTOR = 4,
  parameter  int FLIT_BUFFER_DEPTH    = 4,
  localparam int FLIT_WIDTH           = TDATA_WIDTH / SERIALIZATION_FACTOR
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [FLIT_WIDTH-1:0]  data_in,
  input  logic [TDEST_WIDTH-1:0] dest_in,
  input  logic                   is_tail_in,
  input  logic                   send_in,
  output logic                   credit_out,
  output logic                   axis_tvalid,
  input  logic                   axis_tready,
  output logic [TDATA_WIDTH-1:0] axis_tdata,
  output logic                   axis_tlast,
  output logic [TDEST_WIDTH-1:0] axis_tdest,
  output logic                   err_overflow,
  output logic                   err_tail_misaligned
);
  localparam int LAST    = SERIALIZATION_FACTOR - 1;
  localparam int CNT_W   = $clog2(SERIALIZATION_FACTOR);
  localparam int ENTRY_W = FLIT_WIDTH + TDEST_WIDTH + 1;

  logic [ENTRY_W-1:0]         head;
  logic [FLIT_WIDTH-1:0]      head_data;
  logic [TDEST_WIDTH-1:0]     head_dest;
  logic                       head_tail;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       pop;
  logic                       push;
  logic                       at_last;
  logic [CNT_W-1:0]           cnt;
  logic [LAST*FLIT_WIDTH-1:0] asm_data;
  logic [TDEST_WIDTH-1:0]     asm_dest;

  assign {head_data, head_dest, head_tail} = head;
  assign at_last = (cnt == CNT_W'(LAST));
  // The final flit may only leave the FIFO when the output register can take the beat.
  assign pop  = !fifo_empty && (!at_last || !axis_tvalid || axis_tready);
  assign push = send_in && (!fifo_full || pop);

  axis_flit_deserializer_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(FLIT_BUFFER_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (push),
    .wr_data({data_in, dest_in, is_tail_in}),
    .rd_en  (pop),
    .rd_data(head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt                 <= '0;
      asm_data            <= '0;
      asm_dest            <= '0;
      credit_out          <= 1'b0;
      axis_tvalid         <= 1'b0;
      axis_tdata          <= '0;
      axis_tlast          <= 1'b0;
      axis_tdest          <= '0;
      err_overflow        <= 1'b0;
      err_tail_misaligned <= 1'b0;
    end else begin
      credit_out <= pop;
      if (send_in && fifo_full && !pop) err_overflow <= 1'b1;
      if (axis_tvalid && axis_tready) axis_tvalid <= 1'b0;
      if (pop) begin
        if (at_last) begin
          axis_tdata  <= {head_data, asm_data};
          axis_tdest  <= asm_dest;
          axis_tlast  <= head_tail;
          axis_tvalid <= 1'b1;
          cnt         <= '0;
        end else if (head_tail) begin
          // Tail before the beat is full: drop the partial beat and restart.
          err_tail_misaligned <= 1'b1;
          cnt                 <= '0;
        end else begin
          for (int i = 0; i < LAST; i++) begin
            if (cnt == CNT_W'(i)) asm_data[i*FLIT_WIDTH +: FLIT_WIDTH] <= head_data;
          end
          if (cnt == '0) asm_dest <= head_dest;
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end
endmodule
